// File: rtl/riscv_amo_unit_if.sv
// riscv_amo_unit_if: bundles the memory-stage request, the dcache handshake
// and the result/stall return path of the LR/SC/AMO unit.
//   master : pipeline + dcache side (drives i_*, observes o_*)
//   slave  : riscv_amo_unit (observes i_*, drives o_*)
interface riscv_amo_unit_if;
  logic        i_riscv_amo_valid;
  logic [4:0]  i_riscv_amo_op;
  logic        i_riscv_amo_dword;
  logic [63:0] i_riscv_amo_addr;
  logic [63:0] i_riscv_amo_rs2;
  logic        i_riscv_amo_misaligned;
  logic        i_riscv_amo_flush;
  logic        i_riscv_amo_memack;
  logic [63:0] i_riscv_amo_memrdata;
  logic        o_riscv_amo_memrden;
  logic        o_riscv_amo_memwren;
  logic [63:0] o_riscv_amo_memaddr;
  logic [63:0] o_riscv_amo_memwdata;
  logic        o_riscv_amo_memsize;
  logic        o_riscv_amo_stall;
  logic        o_riscv_amo_done;
  logic [63:0] o_riscv_amo_result;

  modport master (
    output i_riscv_amo_valid, i_riscv_amo_op, i_riscv_amo_dword, i_riscv_amo_addr,
           i_riscv_amo_rs2, i_riscv_amo_misaligned, i_riscv_amo_flush,
           i_riscv_amo_memack, i_riscv_amo_memrdata,
    input  o_riscv_amo_memrden, o_riscv_amo_memwren, o_riscv_amo_memaddr,
           o_riscv_amo_memwdata, o_riscv_amo_memsize, o_riscv_amo_stall,
           o_riscv_amo_done, o_riscv_amo_result
  );

  modport slave (
    input  i_riscv_amo_valid, i_riscv_amo_op, i_riscv_amo_dword, i_riscv_amo_addr,
           i_riscv_amo_rs2, i_riscv_amo_misaligned, i_riscv_amo_flush,
           i_riscv_amo_memack, i_riscv_amo_memrdata,
    output o_riscv_amo_memrden, o_riscv_amo_memwren, o_riscv_amo_memaddr,
           o_riscv_amo_memwdata, o_riscv_amo_memsize, o_riscv_amo_stall,
           o_riscv_amo_done, o_riscv_amo_result
  );
endinterface

// File: rtl/riscv_amo_unit.sv
// riscv_amo_unit: executes LR/SC/AMO instructions of the memory stage as a
// read / modify / write sequence against the dcache and tracks the LR
// reservation.
//   i_riscv_amo_clk : clock, rising edge
//   i_riscv_amo_rst : asynchronous active-high reset
//   amo             : slave modport of riscv_amo_unit_if (request, dcache
//                     handshake, stall, done/result)
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for an accepted LR/SC/AMO
// S_READ  | dcache read of the old value in flight
// S_WRITE | dcache write of the new value (AMO, successful SC)
// S_DONE  | one-cycle done pulse, result valid
module riscv_amo_unit (
  input logic             i_riscv_amo_clk,
  input logic             i_riscv_amo_rst,
  riscv_amo_unit_if.slave amo
);

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SWAP = 5'b00001;
  localparam logic [4:0] OP_LR   = 5'b00010;
  localparam logic [4:0] OP_SC   = 5'b00011;
  localparam logic [4:0] OP_XOR  = 5'b00100;
  localparam logic [4:0] OP_OR   = 5'b01000;
  localparam logic [4:0] OP_AND  = 5'b01100;
  localparam logic [4:0] OP_MIN  = 5'b10000;
  localparam logic [4:0] OP_MAX  = 5'b10100;
  localparam logic [4:0] OP_MINU = 5'b11000;
  localparam logic [4:0] OP_MAXU = 5'b11100;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

  state_t      state;
  logic        resv_valid;
  logic [63:0] resv_addr;
  logic [63:0] old_q;
  logic [4:0]  op_q;
  logic        dword_q;
  logic [63:0] addr_q;
  logic [63:0] rs2_q;
  logic        memrden_q;
  logic        memwren_q;
  logic [63:0] memaddr_q;
  logic [63:0] memwdata_q;
  logic        memsize_q;
  logic        done_q;
  logic [63:0] result_q;

  logic        accepted;
  logic        sc_hit;
  logic [63:0] rdata_ext;

  // Operands are widened to 65 bits, sign-extended only for MIN/MAX, so a
  // single signed compare serves both the signed and unsigned variants.
  function automatic logic [63:0] amo_calc(input logic [4:0] op, input logic dw,
                                           input logic [63:0] old, input logic [63:0] src);
    logic        sgn;
    logic [64:0] a;
    logic [64:0] b;
    logic        lt;
    logic [63:0] r;
    sgn = (op == OP_MIN) || (op == OP_MAX);
    if (dw) begin
      a = {sgn & old[63], old};
      b = {sgn & src[63], src};
    end else begin
      a = {{33{sgn & old[31]}}, old[31:0]};
      b = {{33{sgn & src[31]}}, src[31:0]};
    end
    lt = $signed(a) < $signed(b);
    r  = b[63:0];
    case (op)
      OP_ADD:           r = a[63:0] + b[63:0];
      OP_SWAP:          r = b[63:0];
      OP_XOR:           r = a[63:0] ^ b[63:0];
      OP_OR:            r = a[63:0] | b[63:0];
      OP_AND:           r = a[63:0] & b[63:0];
      OP_MIN, OP_MINU:  r = lt ? a[63:0] : b[63:0];
      OP_MAX, OP_MAXU:  r = lt ? b[63:0] : a[63:0];
      default:          r = b[63:0];
    endcase
    return dw ? r : {32'h0, r[31:0]};
  endfunction

  assign accepted  = amo.i_riscv_amo_valid & ~amo.i_riscv_amo_misaligned & ~amo.i_riscv_amo_flush;
  assign sc_hit    = resv_valid && (resv_addr == amo.i_riscv_amo_addr);
  assign rdata_ext = dword_q ? amo.i_riscv_amo_memrdata
                             : {{32{amo.i_riscv_amo_memrdata[31]}}, amo.i_riscv_amo_memrdata[31:0]};

  always_ff @(posedge i_riscv_amo_clk or posedge i_riscv_amo_rst) begin
    if (i_riscv_amo_rst) begin
      state      <= S_IDLE;
      resv_valid <= 1'b0;
      resv_addr  <= '0;
      old_q      <= '0;
      op_q       <= '0;
      dword_q    <= 1'b0;
      addr_q     <= '0;
      rs2_q      <= '0;
      memrden_q  <= 1'b0;
      memwren_q  <= 1'b0;
      memaddr_q  <= '0;
      memwdata_q <= '0;
      memsize_q  <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
    end else if (amo.i_riscv_amo_flush) begin
      state      <= S_IDLE;
      resv_valid <= 1'b0;
      memrden_q  <= 1'b0;
      memwren_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done_q <= 1'b0;
          if (accepted) begin
            op_q      <= amo.i_riscv_amo_op;
            dword_q   <= amo.i_riscv_amo_dword;
            addr_q    <= amo.i_riscv_amo_addr;
            rs2_q     <= amo.i_riscv_amo_rs2;
            memaddr_q <= amo.i_riscv_amo_addr;
            memsize_q <= amo.i_riscv_amo_dword;
            if (amo.i_riscv_amo_op == OP_SC) begin
              resv_valid <= 1'b0;
              if (sc_hit) begin
                state      <= S_WRITE;
                memwren_q  <= 1'b1;
                memwdata_q <= amo.i_riscv_amo_dword ? amo.i_riscv_amo_rs2
                                                    : {32'h0, amo.i_riscv_amo_rs2[31:0]};
              end else begin
                state    <= S_DONE;
                done_q   <= 1'b1;
                result_q <= 64'd1;
              end
            end else begin
              state     <= S_READ;
              memrden_q <= 1'b1;
            end
          end
        end
        S_READ: begin
          if (amo.i_riscv_amo_memack) begin
            memrden_q <= 1'b0;
            old_q     <= rdata_ext;
            if (op_q == OP_LR) begin
              resv_valid <= 1'b1;
              resv_addr  <= addr_q;
              result_q   <= rdata_ext;
              done_q     <= 1'b1;
              state      <= S_DONE;
            end else begin
              memwren_q  <= 1'b1;
              memwdata_q <= amo_calc(op_q, dword_q, rdata_ext, rs2_q);
              state      <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          if (amo.i_riscv_amo_memack) begin
            memwren_q <= 1'b0;
            done_q    <= 1'b1;
            result_q  <= (op_q == OP_SC) ? 64'd0 : old_q;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          done_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Flush must kill requests and the done pulse in the same cycle, and the
  // accept term of stall must not leak through while reset is held.
  assign amo.o_riscv_amo_memrden  = memrden_q & ~amo.i_riscv_amo_flush;
  assign amo.o_riscv_amo_memwren  = memwren_q & ~amo.i_riscv_amo_flush;
  assign amo.o_riscv_amo_memaddr  = memaddr_q;
  assign amo.o_riscv_amo_memwdata = memwdata_q;
  assign amo.o_riscv_amo_memsize  = memsize_q;
  assign amo.o_riscv_amo_done     = done_q & ~amo.i_riscv_amo_flush;
  assign amo.o_riscv_amo_result   = result_q;
  assign amo.o_riscv_amo_stall    = ~i_riscv_amo_rst &
                                    (((state == S_IDLE) & accepted) |
                                     (state == S_READ) | (state == S_WRITE));

endmodule

// File: tb/tb_riscv_amo_unit.sv
module tb_riscv_amo_unit;

  localparam logic [4:0] ADD  = 5'b00000;
  localparam logic [4:0] SWAP = 5'b00001;
  localparam logic [4:0] LR   = 5'b00010;
  localparam logic [4:0] SC   = 5'b00011;
  localparam logic [4:0] XOR  = 5'b00100;
  localparam logic [4:0] OR   = 5'b01000;
  localparam logic [4:0] AND  = 5'b01100;
  localparam logic [4:0] MIN  = 5'b10000;
  localparam logic [4:0] MAX  = 5'b10100;
  localparam logic [4:0] MINU = 5'b11000;
  localparam logic [4:0] MAXU = 5'b11100;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  riscv_amo_unit_if bus ();

  riscv_amo_unit dut (
    .i_riscv_amo_clk (clk),
    .i_riscv_amo_rst (rst),
    .amo             (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // reference state: memory image and reservation
  logic [63:0] mem [logic [63:0]];
  bit          m_resv_valid;
  logic [63:0] m_resv_addr;

  logic [63:0] last_result;
  logic [63:0] last_wdata;
  int          last_stall;

  logic [4:0]  op_tab [11] = '{ADD, SWAP, LR, SC, XOR, OR, AND, MIN, MAX, MINU, MAXU};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mem_rd(input logic [63:0] a);
    return mem.exists(a) ? mem[a] : 64'h0;
  endfunction

  function automatic logic [63:0] sx32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // New memory value of an AMO, straight from the arithmetic definition.
  function automatic logic [63:0] ref_new(input logic [4:0] op, input bit dw,
                                          input logic [63:0] old, input logic [63:0] src);
    longint          so, ss;
    longint unsigned uo, us;
    logic [63:0]     r;
    if (dw) begin
      so = old; ss = src; uo = old; us = src;
    end else begin
      so = longint'(int'(old[31:0]));
      ss = longint'(int'(src[31:0]));
      uo = longint'({32'h0, old[31:0]});
      us = longint'({32'h0, src[31:0]});
    end
    case (op)
      ADD:     r = uo + us;
      SWAP:    r = us;
      XOR:     r = uo ^ us;
      OR:      r = uo | us;
      AND:     r = uo & us;
      MIN:     r = (so < ss) ? uo : us;
      MAX:     r = (so > ss) ? uo : us;
      MINU:    r = (uo < us) ? uo : us;
      MAXU:    r = (uo > us) ? uo : us;
      default: r = us;
    endcase
    if (!dw) r = {32'h0, r[31:0]};
    return r;
  endfunction

  // Presents one instruction, plays the dcache with the given ack delays,
  // and checks the outcome against the reference model.
  task automatic run_op(input string tag, input logic [4:0] op, input bit dw,
                        input logic [63:0] addr, input logic [63:0] rs2,
                        input int rd_dly, input int wr_dly, input bit flush_at_write);
    logic [63:0] raw, oldx, exp_result, exp_wdata, got_result, got_wdata;
    bit          exp_rd, exp_wr, saw_rd, saw_wr, got_done, flushed;
    int          exp_stall, stall_cnt, rd_wait, wr_wait;
    raw  = mem_rd(addr);
    oldx = dw ? raw : sx32(raw[31:0]);
    exp_wdata = '0; exp_rd = 0; exp_wr = 0;
    if (op == LR) begin
      exp_rd = 1; exp_result = oldx; exp_stall = 2 + rd_dly;
    end else if (op == SC) begin
      if (m_resv_valid && m_resv_addr == addr) begin
        exp_wr = 1; exp_result = 0; exp_stall = 2 + wr_dly;
        exp_wdata = dw ? rs2 : {32'h0, rs2[31:0]};
      end else begin
        exp_result = 1; exp_stall = 1;
      end
    end else begin
      exp_rd = 1; exp_wr = 1; exp_result = oldx; exp_stall = 3 + rd_dly + wr_dly;
      exp_wdata = ref_new(op, dw, raw, rs2);
    end

    saw_rd = 0; saw_wr = 0; got_done = 0; flushed = 0;
    stall_cnt = 0; rd_wait = 0; wr_wait = 0;
    got_result = 'x; got_wdata = 'x;
    @(negedge clk);
    bus.i_riscv_amo_valid = 1'b1;
    bus.i_riscv_amo_op    = op;
    bus.i_riscv_amo_dword = dw;
    bus.i_riscv_amo_addr  = addr;
    bus.i_riscv_amo_rs2   = rs2;
    for (int cyc = 0; cyc < 60; cyc++) begin
      #1;
      check({tag, "_rd_wr_excl"}, 64'(bus.o_riscv_amo_memrden & bus.o_riscv_amo_memwren), 0);
      if (bus.o_riscv_amo_stall) stall_cnt++;
      bus.i_riscv_amo_memack = 1'b0;
      if (bus.o_riscv_amo_done) begin
        got_done   = 1;
        got_result = bus.o_riscv_amo_result;
        bus.i_riscv_amo_valid = 1'b0;
        break;
      end
      if (bus.o_riscv_amo_memrden) begin
        saw_rd = 1;
        check({tag, "_rd_addr"}, bus.o_riscv_amo_memaddr, addr);
        check({tag, "_rd_size"}, 64'(bus.o_riscv_amo_memsize), 64'(dw));
        if (rd_wait == rd_dly) begin
          bus.i_riscv_amo_memack   = 1'b1;
          bus.i_riscv_amo_memrdata = dw ? raw : {32'($urandom), raw[31:0]};
        end else rd_wait++;
      end
      if (bus.o_riscv_amo_memwren) begin
        saw_wr = 1;
        check({tag, "_wr_addr"}, bus.o_riscv_amo_memaddr, addr);
        if (flush_at_write) begin
          bus.i_riscv_amo_flush = 1'b1;
          #1;
          check({tag, "_flush_wren_gated"}, 64'(bus.o_riscv_amo_memwren), 0);
          @(negedge clk);
          bus.i_riscv_amo_flush = 1'b0;
          bus.i_riscv_amo_valid = 1'b0;
          #1;
          check({tag, "_flush_no_done"}, 64'(bus.o_riscv_amo_done), 0);
          check({tag, "_flush_idle_stall"}, 64'(bus.o_riscv_amo_stall), 0);
          check({tag, "_flush_idle_wren"}, 64'(bus.o_riscv_amo_memwren), 0);
          flushed = 1;
          break;
        end
        if (wr_wait == wr_dly) begin
          bus.i_riscv_amo_memack = 1'b1;
          got_wdata = bus.o_riscv_amo_memwdata;
        end else wr_wait++;
      end
      @(negedge clk);
    end
    bus.i_riscv_amo_memack = 1'b0;
    bus.i_riscv_amo_valid  = 1'b0;

    if (flushed) begin
      m_resv_valid = 0;
      @(negedge clk); #1;
      check({tag, "_flush_still_no_done"}, 64'(bus.o_riscv_amo_done), 0);
    end else begin
      check({tag, "_done_seen"}, 64'(got_done), 1);
      check({tag, "_result"}, got_result, exp_result);
      check({tag, "_stall_cycles"}, 64'(stall_cnt), 64'(exp_stall));
      check({tag, "_read_issued"}, 64'(saw_rd), 64'(exp_rd));
      check({tag, "_write_issued"}, 64'(saw_wr), 64'(exp_wr));
      if (exp_wr) check({tag, "_wdata"}, got_wdata, exp_wdata);
      @(negedge clk); #1;
      check({tag, "_done_one_pulse"}, 64'(bus.o_riscv_amo_done), 0);
      if (exp_wr) mem[addr] = exp_wdata;
      if (op == LR) begin m_resv_valid = 1; m_resv_addr = addr; end
      if (op == SC) m_resv_valid = 0;
    end
    last_result = got_result;
    last_wdata  = got_wdata;
    last_stall  = stall_cnt;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_riscv_amo_valid      = 1'b0;
    bus.i_riscv_amo_op         = '0;
    bus.i_riscv_amo_dword      = 1'b0;
    bus.i_riscv_amo_addr       = '0;
    bus.i_riscv_amo_rs2        = '0;
    bus.i_riscv_amo_misaligned = 1'b0;
    bus.i_riscv_amo_flush      = 1'b0;
    bus.i_riscv_amo_memack     = 1'b0;
    bus.i_riscv_amo_memrdata   = '0;
    m_resv_valid = 0;
    m_resv_addr  = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_memrden",  64'(bus.o_riscv_amo_memrden), 0);
    check("rst_memwren",  64'(bus.o_riscv_amo_memwren), 0);
    check("rst_memaddr",  bus.o_riscv_amo_memaddr, 0);
    check("rst_memwdata", bus.o_riscv_amo_memwdata, 0);
    check("rst_memsize",  64'(bus.o_riscv_amo_memsize), 0);
    check("rst_stall",    64'(bus.o_riscv_amo_stall), 0);
    check("rst_done",     64'(bus.o_riscv_amo_done), 0);
    check("rst_result",   bus.o_riscv_amo_result, 0);
    rst = 1'b0;

    mem[64'h1000] = 64'h1234;
    mem[64'h2000] = 64'hDEAD_BEEF_0000_0001;
    mem[64'h3000] = 64'h0000_0000_7FFF_FFFF;
    mem[64'h5000] = 64'h5555_0000_5555_0000;
    mem[64'h6000] = 64'h0123_4567_89AB_CDEF;

    // LR.D then SC.D on the reserved address
    run_op("lr_d", LR, 1, 64'h1000, 64'h0, 2, 0, 0);
    check("lr_d_value", last_result, 64'h1234);
    run_op("sc_d", SC, 1, 64'h1000, 64'hAA, 0, 1, 0);
    check("sc_d_wdata", last_wdata, 64'hAA);
    check("sc_d_value", last_result, 64'h0);

    // SC.W without reservation
    run_op("sc_w_norsv", SC, 0, 64'h2000, 64'h55, 0, 0, 0);
    check("sc_w_norsv_value", last_result, 64'h1);
    check("sc_w_norsv_stall", 64'(last_stall), 1);

    // AMOADD.W overflow wrap
    run_op("amoadd_w", ADD, 0, 64'h3000, 64'h1, 0, 0, 0);
    check("amoadd_w_wdata", last_wdata, 64'h8000_0000);
    check("amoadd_w_value", last_result, 64'h0000_0000_7FFF_FFFF);
    check("amoadd_w_stall", 64'(last_stall), 3);

    // AMOMINU.W vs AMOMIN.W
    mem[64'h3008] = 64'h0000_0000_FFFF_FFFF;
    run_op("amominu_w", MINU, 0, 64'h3008, 64'h1, 0, 0, 0);
    check("amominu_w_wdata", last_wdata, 64'h1);
    check("amominu_w_value", last_result, 64'hFFFF_FFFF_FFFF_FFFF);
    mem[64'h3008] = 64'h0000_0000_FFFF_FFFF;
    run_op("amomin_w", MIN, 0, 64'h3008, 64'h1, 1, 0, 0);
    check("amomin_w_wdata", last_wdata, 64'h0000_0000_FFFF_FFFF);
    check("amomin_w_value", last_result, 64'hFFFF_FFFF_FFFF_FFFF);

    // flush during WRITE kills the op and the reservation
    run_op("lr_d_6000", LR, 1, 64'h6000, 64'h0, 0, 0, 0);
    run_op("amoswap_flush", SWAP, 1, 64'h6000, 64'hFACE, 0, 0, 1);
    run_op("sc_after_flush", SC, 1, 64'h6000, 64'h77, 0, 0, 0);
    check("sc_after_flush_value", last_result, 64'h1);

    // misaligned request is ignored
    @(negedge clk);
    bus.i_riscv_amo_valid      = 1'b1;
    bus.i_riscv_amo_op         = ADD;
    bus.i_riscv_amo_addr       = 64'h3003;
    bus.i_riscv_amo_misaligned = 1'b1;
    #1;
    check("misaligned_stall", 64'(bus.o_riscv_amo_stall), 0);
    @(negedge clk); #1;
    check("misaligned_rden", 64'(bus.o_riscv_amo_memrden), 0);
    bus.i_riscv_amo_valid      = 1'b0;
    bus.i_riscv_amo_misaligned = 1'b0;

    // reset while READ waits for ack
    run_op("lr_d_5000", LR, 1, 64'h5000, 64'h0, 0, 0, 0);
    @(negedge clk);
    bus.i_riscv_amo_valid = 1'b1;
    bus.i_riscv_amo_op    = LR;
    bus.i_riscv_amo_dword = 1'b1;
    bus.i_riscv_amo_addr  = 64'h4000;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (bus.o_riscv_amo_memrden) break;
      @(negedge clk);
    end
    check("rst_mid_read_rden_before", 64'(bus.o_riscv_amo_memrden), 1);
    #1 rst = 1'b1;
    #1;
    check("rst_mid_read_rden", 64'(bus.o_riscv_amo_memrden), 0);
    check("rst_mid_read_stall", 64'(bus.o_riscv_amo_stall), 0);
    bus.i_riscv_amo_valid = 1'b0;
    rst = 1'b0;
    m_resv_valid = 0;
    @(negedge clk); #1;
    check("rst_mid_read_idle_stall", 64'(bus.o_riscv_amo_stall), 0);
    check("rst_mid_read_idle_rden", 64'(bus.o_riscv_amo_memrden), 0);
    run_op("sc_after_rst", SC, 1, 64'h5000, 64'h99, 0, 0, 0);
    check("sc_after_rst_value", last_result, 64'h1);

    // randomized sequence over a small address pool
    for (int a = 0; a < 4; a++) mem[64'h100 + 64'(8 * a)] = {$urandom, $urandom};
    for (int i = 0; i < 60; i++) begin
      logic [4:0]  rop;
      logic [63:0] raddr;
      rop   = op_tab[$urandom_range(0, 10)];
      raddr = 64'h100 + 64'(8 * $urandom_range(0, 3));
      run_op($sformatf("rand%0d", i), rop, bit'($urandom_range(0, 1)), raddr,
             {$urandom, $urandom}, $urandom_range(0, 2), $urandom_range(0, 2), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
